// File: rtl/miriscv_timer_pkg.sv
// Shared definitions for the miriscv timer: register offsets, CTRL layout and byte-lane merge.
package miriscv_timer_pkg;

    localparam logic [4:0] TIMER_CTRL_OFF     = 5'h00;
    localparam logic [4:0] TIMER_PRESCALE_OFF = 5'h04;
    localparam logic [4:0] TIMER_COUNT_OFF    = 5'h08;
    localparam logic [4:0] TIMER_COMPARE_OFF  = 5'h0C;
    localparam logic [4:0] TIMER_STATUS_OFF   = 5'h10;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_IE_BIT      = 1;
    localparam int unsigned CTRL_ONESHOT_BIT = 2;

    typedef struct packed {
        logic oneshot;
        logic ie;
        logic en;
    } timer_ctrl_t;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/miriscv_timer_prescaler.sv
// Tick generator: one tick every PRESCALE+1 enabled cycles.
// Built only with MIRISCV_TIMER_PRESCALER_EN; otherwise every enabled cycle is a tick.
module miriscv_timer_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

`ifdef MIRISCV_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

    assign tick_o = en_i && (pcnt_q == prescale_i);

    // A prescale below pcnt is only reached after pcnt wraps through 2^PRESCALE_W.
    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (!en_i || tick_o || clr_i) pcnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pcnt_q <= '0;
        else          pcnt_q <= pcnt_d;
    end
`else
    logic unused_prescaler;
    assign unused_prescaler = ^{clk_i, rst_n_i, clr_i, prescale_i};
    assign tick_o = en_i;
`endif

endmodule

// File: rtl/miriscv_timer.sv
// Memory-mapped 32-bit compare timer with level interrupt request.
// Optional prescaler enabled by defining MIRISCV_TIMER_PRESCALER_EN.
module miriscv_timer
    import miriscv_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        int_req_o,
    input  logic        int_fin_i
);

    timer_ctrl_t           ctrl_q, ctrl_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [4:0]            off;
    logic                  wr, wr_ctrl, wr_count, wr_compare, wr_status;
    logic                  tick, hit;
    logic                  unused_addr;

    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

    assign off        = {addr_i[4:2], 2'b00};
    assign wr         = req_i & we_i;
    assign wr_ctrl    = wr && (off == TIMER_CTRL_OFF) && be_i[0];
    assign wr_count   = wr && (off == TIMER_COUNT_OFF);
    assign wr_compare = wr && (off == TIMER_COMPARE_OFF);
    assign wr_status  = wr && (off == TIMER_STATUS_OFF) && be_i[0];

`ifdef MIRISCV_TIMER_PRESCALER_EN
    logic [31:0] prescale_merged;

    assign prescale_merged = apply_be(32'(prescale_q), wdata_i, be_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prescale_q <= '0;
        end else if (wr && (off == TIMER_PRESCALE_OFF)) begin
            prescale_q <= prescale_merged[PRESCALE_W-1:0];
        end
    end
`else
    assign prescale_q = '0;
`endif

    miriscv_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (ctrl_q.en),
        .clr_i      (wr_count),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );

    assign hit = tick && (count_q == compare_q);

    // Software writes beat tick effects; a tick match beats any MATCH clear.
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;

        if (wr_ctrl)                      ctrl_d    = timer_ctrl_t'(wdata_i[2:0]);
        else if (hit && ctrl_q.oneshot)   ctrl_d.en = 1'b0;

        if (wr_count)  count_d = apply_be(count_q, wdata_i, be_i);
        else if (tick) count_d = hit ? 32'd0 : count_q + 32'd1;

        if (wr_compare) compare_d = apply_be(compare_q, wdata_i, be_i);

        if (hit)                                           match_d = 1'b1;
        else if (int_fin_i || (wr_status && wdata_i[0]))   match_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (off)
            TIMER_CTRL_OFF:     rdata_o = {29'd0, ctrl_q};
            TIMER_PRESCALE_OFF: rdata_o = 32'(prescale_q);
            TIMER_COUNT_OFF:    rdata_o = count_q;
            TIMER_COMPARE_OFF:  rdata_o = compare_q;
            TIMER_STATUS_OFF:   rdata_o = {31'd0, match_q};
            default:            rdata_o = '0;
        endcase
    end

    assign int_req_o = match_q & ctrl_q.ie;

endmodule

// File: tb/tb_miriscv_timer.sv
// Self-checking bench for miriscv_timer: directed scenarios plus randomized traffic vs a reference model.
module tb_miriscv_timer;

`ifdef MIRISCV_TIMER_PRESCALER_EN
    localparam bit HAS_PRE = 1'b1;
`else
    localparam bit HAS_PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, fin;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        int_req;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [2:0]  m_ctrl;
    logic [31:0] m_pre, m_count, m_cmp;
    logic        m_match;
    int unsigned m_pcnt;

    always #5 clk = ~clk;

    miriscv_timer #(
        .PRESCALE_W (16)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .we_i      (we),
        .be_i      (be),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .int_req_o (int_req),
        .int_fin_i (fin)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] w);
        case (w)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return m_pre;
            3'd2: return m_count;
            3'd3: return m_cmp;
            3'd4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 3'd0; m_pre = 0; m_count = 0; m_cmp = 0; m_match = 1'b0; m_pcnt = 0;
    endtask

    // Applies the register rules for one clock edge with the given bus/ack inputs.
    task automatic model_edge(input logic r, input logic w_en, input logic [3:0] b,
                              input logic [2:0] w, input logic [31:0] d, input logic f);
        bit          wr, tick, hit;
        logic [2:0]  n_ctrl;
        logic [31:0] n_pre, n_count, n_cmp;
        logic        n_match;
        int unsigned n_pcnt;
        wr   = r && w_en;
        tick = m_ctrl[0] && (HAS_PRE ? (m_pcnt == m_pre) : 1'b1);
        hit  = tick && (m_count == m_cmp);

        n_ctrl = m_ctrl;
        if (wr && w == 3'd0 && b[0]) n_ctrl = d[2:0];
        else if (hit && m_ctrl[2])   n_ctrl[0] = 1'b0;

        n_pre = m_pre;
        if (HAS_PRE && wr && w == 3'd1) n_pre = merge(m_pre, d, b) & 32'h0000_FFFF;

        n_count = m_count;
        if (wr && w == 3'd2) n_count = merge(m_count, d, b);
        else if (tick)       n_count = hit ? 32'd0 : m_count + 32'd1;

        n_cmp = m_cmp;
        if (wr && w == 3'd3) n_cmp = merge(m_cmp, d, b);

        n_match = m_match;
        if (hit) n_match = 1'b1;
        else if (f || (wr && w == 3'd4 && b[0] && d[0])) n_match = 1'b0;

        if (!m_ctrl[0] || tick || (wr && w == 3'd2)) n_pcnt = 0;
        else                                         n_pcnt = (m_pcnt + 1) % 65536;

        m_ctrl = n_ctrl; m_pre = n_pre; m_count = n_count; m_cmp = n_cmp;
        m_match = n_match; m_pcnt = n_pcnt;
    endtask

    task automatic cycle(input logic r, input logic w_en, input logic [3:0] b,
                         input logic [2:0] w, input logic [31:0] d, input logic f);
        req = r; we = w_en; be = b; addr = {27'd0, w, 2'b00}; wdata = d; fin = f;
        @(posedge clk);
        model_edge(r, w_en, b, w, d, f);
        #1;
        req = 1'b0; we = 1'b0; fin = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] w, input logic [31:0] d);
        cycle(1'b1, 1'b1, 4'hF, w, d, 1'b0);
    endtask

    task automatic peek(input logic [2:0] w);
        addr = {27'd0, w, 2'b00};
        #1;
    endtask

    task automatic do_reset();
        req = 1'b0; we = 1'b0; fin = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0;
        rst_n = 1'b0;
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int w = 0; w < 5; w++) begin
            peek(3'(w));
            checks++;
            if (rdata !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", w, rdata, 32'd0);
            end
        end
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL reset_int_req: got %b expected 0", int_req);
        end
        // Pending interrupt killed by asynchronous reset without a clock edge
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd3);
        idle();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL pre_reset_int_req: got %b expected 1", int_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL async_reset_int_req: got %b expected 0", int_req);
        end
        peek(3'd0);
        checks++;
        if (rdata !== 32'd0) begin
            errors++; $display("FAIL async_reset_ctrl: got %h expected 0", rdata);
        end
        do_reset();
    endtask

    task automatic test_prescale();
        int n, exp_n;
        do_reset();
        wr(3'd1, 32'd3);
        wr(3'd3, 32'd4);
        wr(3'd0, 32'd3);
        exp_n = HAS_PRE ? 20 : 5;
        n = 0;
        while (int_req !== 1'b1 && n < 200) begin idle(); n++; end
        checks++;
        if (n != exp_n) begin
            errors++; $display("FAIL prescale_first_rise: got %0d cycles expected %0d", n, exp_n);
        end
        cycle(1'b0, 1'b0, 4'h0, 3'd0, 32'd0, 1'b1);
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL fin_drop: got %b expected 0", int_req);
        end
        n = 1;
        while (int_req !== 1'b1 && n < 200) begin idle(); n++; end
        checks++;
        if (n != exp_n) begin
            errors++; $display("FAIL prescale_second_rise: got %0d cycles expected %0d", n, exp_n);
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(3'd3, 32'd2);
        wr(3'd0, 32'd7);
        idle(); idle();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL oneshot_early: got %b expected 0", int_req);
        end
        idle();
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL oneshot_match: got %b expected 1", int_req);
        end
        peek(3'd0);
        checks++;
        if (rdata !== 32'd6) begin
            errors++; $display("FAIL oneshot_ctrl: got %h expected %h", rdata, 32'd6);
        end
        idle(); idle(); idle();
        peek(3'd2);
        checks++;
        if (rdata !== 32'd0) begin
            errors++; $display("FAIL oneshot_count_hold: got %h expected 0", rdata);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [3];
        seq[0] = 32'hFFFF_FFFF; seq[1] = 32'h0; seq[2] = 32'h1;
        do_reset();
        wr(3'd2, 32'hFFFF_FFFE);
        wr(3'd3, 32'd1);
        wr(3'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            peek(3'd2);
            checks++;
            if (rdata !== seq[i]) begin
                errors++; $display("FAIL wrap_count%0d: got %h expected %h", i, rdata, seq[i]);
            end
        end
        peek(3'd4);
        checks++;
        if (rdata !== 32'd0) begin
            errors++; $display("FAIL wrap_no_match_yet: got %h expected 0", rdata);
        end
        idle();
        peek(3'd4);
        checks++;
        if (rdata !== 32'd1) begin
            errors++; $display("FAIL wrap_match: got %h expected 1", rdata);
        end
    endtask

    task automatic test_collision();
        do_reset();
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd1);
        idle();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL ie_gate: got %b expected 0", int_req);
        end
        cycle(1'b0, 1'b0, 4'h0, 3'd0, 32'd0, 1'b1);
        peek(3'd4);
        checks++;
        if (rdata !== 32'd1) begin
            errors++; $display("FAIL fin_vs_tick: got %h expected 1", rdata);
        end
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd0);
        peek(3'd4);
        checks++;
        if (rdata !== 32'd1) begin
            errors++; $display("FAIL status_write0: got %h expected 1", rdata);
        end
        wr(3'd4, 32'd1);
        peek(3'd4);
        checks++;
        if (rdata !== 32'd0) begin
            errors++; $display("FAIL status_write1: got %h expected 0", rdata);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] exp_v [8];
        do_reset();
        cycle(1'b1, 1'b1, 4'b0010, 3'd3, 32'hAABB_CCDD, 1'b0);
        peek(3'd3);
        checks++;
        if (rdata !== 32'h0000_CC00) begin
            errors++; $display("FAIL be_compare: got %h expected %h", rdata, 32'h0000_CC00);
        end
        cycle(1'b1, 1'b1, 4'hF, 3'd6, 32'hFFFF_FFFF, 1'b0);
        for (int w = 0; w < 8; w++) exp_v[w] = 32'd0;
        exp_v[3] = 32'h0000_CC00;
        for (int w = 0; w < 8; w++) begin
            peek(3'(w));
            checks++;
            if (rdata !== exp_v[w]) begin
                errors++;
                $display("FAIL unmapped_write_reg%0d: got %h expected %h", w, rdata, exp_v[w]);
            end
        end
    endtask

    task automatic test_random();
        logic        r, w_en, f;
        logic [3:0]  b;
        logic [2:0]  w, rw;
        logic [31:0] d, exp_v;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 3) == 0);
            w_en = ($urandom_range(0, 3) != 0);
            f    = ($urandom_range(0, 7) == 0);
            b    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            w    = 3'($urandom_range(0, 7));
            case (w)
                3'd0:    d = 32'($urandom_range(0, 7));
                3'd1:    d = 32'($urandom_range(0, 3));
                3'd2:    d = 32'($urandom_range(0, 8));
                3'd3:    d = 32'($urandom_range(0, 10));
                default: d = $urandom;
            endcase
            cycle(r, w_en, b, w, d, f);
            checks++;
            if (int_req !== (m_match & m_ctrl[1])) begin
                errors++;
                $display("FAIL rand_int_req[%0d]: got %b expected %b", i, int_req,
                         m_match & m_ctrl[1]);
            end
            rw = 3'($urandom_range(0, 7));
            peek(rw);
            exp_v = m_read(rw);
            checks++;
            if (rdata !== exp_v) begin
                errors++;
                $display("FAIL rand_read[%0d] reg%0d: got %h expected %h", i, rw, rdata, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; fin = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0;
        model_reset();
        test_reset();
        test_prescale();
        test_oneshot();
        test_wrap();
        test_collision();
        test_byte_enable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
